sha2_core: RTL and testbench
============================

Name: sha2_core

Overview:
Parametrised SHA-2 compression engine covering SHA-224/256 (32-bit words, 64 rounds) and SHA-384/512 (64-bit words, 80 rounds). It replaces in-core end-of-message byte detection with explicit block framing. It uses valid/ready handshakes on block input and digest output. It sits behind the register interface, which supplies pre-padded blocks and drains digests.

Parameters:
WordWidth, 32, word size in bits; legal values 32 or 64.
DigestWidth, 256, digest size; legal values 224/256 when WordWidth=32, 384/512 when WordWidth=64; any other combination is an elaboration error.
BlockWidth, 16*WordWidth, derived and not overridable; message block size.
NumRounds, 64 if WordWidth=32 else 80, derived; rounds per block.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
block_i  in  BlockWidth  pre-padded block; W0 = block_i[BlockWidth-1 -: WordWidth] (big-endian word order)
block_last_i  in  1  block is the final block of its message; qualified by block_valid_i
block_valid_i  in  1  block_i/block_last_i valid
block_ready_o  out  1  core accepts a block this cycle
abort_i  in  1  synchronous abort of the current message
digest_o  out  DigestWidth  final digest: top DigestWidth bits of {H0..H7}, H0 in MSBs
digest_valid_o  out  1  digest_o valid
digest_ready_i  in  1  consumer accepts digest
round_o  out  7  current round index, 0..NumRounds-1
block_cnt_o  out  32  blocks absorbed into the current message; wraps modulo 2^32

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state IDLE, first-block flag set.
  - block_ready_o=0 during reset, 1 from the first cycle after release.
  - digest_valid_o=0, digest_o=0, round_o=0, block_cnt_o=0.
  - Working regs a..h=0 and H regs=0.
- States: IDLE, ROUND, UPDATE, DONE.
- IDLE:
  - block_ready_o = ~abort_i.
  - On block_valid_i & block_ready_o (edge T): latch block into a 16-word schedule window and latch block_last_i.
  - If first-block flag is set, load H0..H7 with the FIPS 180-4 IV for the variant (224/256/384/512), and load a..h with that IV.
  - Otherwise load a..h from the current H. Clear the first-block flag.
  - Go to ROUND with round counter 0.
- ROUND:
  - One round per cycle, at edges T+1..T+NumRounds.
  - Rounds 0..15 use W_t from the window.
  - Rounds 16+ compute W_t with WordWidth-appropriate sigma0/sigma1 rotate/shift amounts, then shift the window by one word.
  - K_t comes from a 64- or 80-entry table selected by WordWidth.
  - All additions are modulo 2^WordWidth.
  - round_o shows the index of the round being computed. After round NumRounds-1, go to UPDATE.
- UPDATE (edge T+NumRounds+1):
  - Hi <= Hi + working reg i, modulo 2^WordWidth.
  - block_cnt_o increments.
  - Next state is DONE if the latched last flag is set, else IDLE.
  - Block-to-block throughput is NumRounds+2 cycles.
- DONE:
  - digest_valid_o=1 and block_ready_o=0.
  - digest_o is held stable until digest_valid_o & digest_ready_i.
  - On that handshake: go to IDLE, set the first-block flag, clear block_cnt_o.
  - digest_valid_o deasserts the next cycle.
- abort_i in any state:
  - Next state IDLE, first-block flag set, digest_valid_o=0, block_cnt_o=0, round_o=0.
  - In-flight block is discarded, and H is not updated.
  - abort_i beats a same-cycle block handshake (no block is accepted) and a same-cycle digest handshake (the digest is dropped).
- Input stability: block_i and block_last_i are sampled only at the accepting edge. Changes while not ready have no effect.
- digest_o is only meaningful while digest_valid_o=1. Between messages it holds the last value until overwritten.
- block_valid_i held high while block_ready_o=0 is legal; the block is accepted on the first ready cycle.

Test Plan:
- SHA-256, one block "abc" (0x61626380, 13 zero words, 0x00000018), last=1:
  - digest_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - digest_valid_o rises 66 cycles after the accepting edge.
  - block_cnt_o = 1.
- SHA-256, two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", last on block 2 only:
  - digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - block_ready_o re-asserts between the blocks.
- Variant sweep, "abc":
  - DigestWidth=224: 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
  - WordWidth=64/512: ddaf35a193617aba...a54ca49f, with 82-cycle latency.
  - WordWidth=64/384: cb00753f45a35e8b...34c825a7.
- Digest backpressure:
  - Hold digest_ready_i=0 for 20 cycles; digest_valid_o and digest_o stay stable and block_ready_o stays 0.
  - Assert digest_ready_i for 1 cycle; the next cycle gives IDLE with block_ready_o=1.
  - A new "abc" message then gives the same digest (first-block IV reload).
- Abort mid-message:
  - Assert abort_i at round 30 of block 1 of a two-block message; next cycle IDLE, block_cnt_o=0.
  - Re-sending one-block "abc" gives the standard digest.
  - Assert abort_i together with block_valid_i in IDLE; the block is not accepted.
- Async reset mid-ROUND:
  - All outputs return to reset values immediately.
  - After release, "abc" hashes correctly.

Source files
------------

// File: rtl/sha2_core_if.sv
// rtl/sha2_core_if.sv - block-in / digest-out handshake bundle for sha2_core
interface sha2_core_if #(
  parameter int WordWidth   = 32,
  parameter int DigestWidth = 256
);
  localparam int BlockWidth = 16 * WordWidth;

  logic [BlockWidth-1:0]  block_i;
  logic                   block_last_i;
  logic                   block_valid_i;
  logic                   block_ready_o;
  logic                   abort_i;
  logic [DigestWidth-1:0] digest_o;
  logic                   digest_valid_o;
  logic                   digest_ready_i;
  logic [6:0]             round_o;
  logic [31:0]            block_cnt_o;

  modport master (
    output block_i, block_last_i, block_valid_i, abort_i, digest_ready_i,
    input  block_ready_o, digest_o, digest_valid_o, round_o, block_cnt_o
  );

  modport slave (
    input  block_i, block_last_i, block_valid_i, abort_i, digest_ready_i,
    output block_ready_o, digest_o, digest_valid_o, round_o, block_cnt_o
  );
endinterface

// File: rtl/sha2_core.sv
// rtl/sha2_core.sv - SHA-224/256/384/512 compression engine with framed block input
module sha2_core #(
  parameter int WordWidth   = 32,
  parameter int DigestWidth = 256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  sha2_core_if.slave bus
);

  localparam int BlockWidth = 16 * WordWidth;
  localparam int NumRounds  = (WordWidth == 32) ? 64 : 80;
  localparam logic [6:0] LastRound = 7'(NumRounds - 1);

  if (!((WordWidth == 32 && (DigestWidth == 224 || DigestWidth == 256)) ||
        (WordWidth == 64 && (DigestWidth == 384 || DigestWidth == 512)))) begin : g_bad_params
    $error("sha2_core: illegal WordWidth/DigestWidth combination");
  end

  localparam int BS0A = (WordWidth == 32) ? 2  : 28;
  localparam int BS0B = (WordWidth == 32) ? 13 : 34;
  localparam int BS0C = (WordWidth == 32) ? 22 : 39;
  localparam int BS1A = (WordWidth == 32) ? 6  : 14;
  localparam int BS1B = (WordWidth == 32) ? 11 : 18;
  localparam int BS1C = (WordWidth == 32) ? 25 : 41;
  localparam int SS0A = (WordWidth == 32) ? 7  : 1;
  localparam int SS0B = (WordWidth == 32) ? 18 : 8;
  localparam int SS0C = (WordWidth == 32) ? 3  : 7;
  localparam int SS1A = (WordWidth == 32) ? 17 : 19;
  localparam int SS1B = (WordWidth == 32) ? 19 : 61;
  localparam int SS1C = (WordWidth == 32) ? 10 : 6;

  // SHA-256 round constants are the upper 32 bits of the first 64 SHA-512 ones.
  localparam logic [63:0] K [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  // The 256 IV is the upper half of the 512 IV, the 224 IV the lower half of the 384 IV.
  localparam logic [63:0] IV512 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };
  localparam logic [63:0] IV384 [8] = '{
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
  };

  function automatic logic [WordWidth-1:0] iv_word(input int i);
    if (DigestWidth == 224)      return IV384[i][WordWidth-1:0];
    else if (DigestWidth == 384) return IV384[i][63 -: WordWidth];
    else                         return IV512[i][63 -: WordWidth];
  endfunction

  function automatic logic [WordWidth-1:0] rotr(input logic [WordWidth-1:0] x, input int n);
    return (x >> n) | (x << (WordWidth - n));
  endfunction

  function automatic logic [WordWidth-1:0] big_s0(input logic [WordWidth-1:0] x);
    return rotr(x, BS0A) ^ rotr(x, BS0B) ^ rotr(x, BS0C);
  endfunction

  function automatic logic [WordWidth-1:0] big_s1(input logic [WordWidth-1:0] x);
    return rotr(x, BS1A) ^ rotr(x, BS1B) ^ rotr(x, BS1C);
  endfunction

  function automatic logic [WordWidth-1:0] small_s0(input logic [WordWidth-1:0] x);
    return rotr(x, SS0A) ^ rotr(x, SS0B) ^ (x >> SS0C);
  endfunction

  function automatic logic [WordWidth-1:0] small_s1(input logic [WordWidth-1:0] x);
    return rotr(x, SS1A) ^ rotr(x, SS1B) ^ (x >> SS1C);
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DONE} state_e;

  state_e                 r_state;
  state_e                 w_next_state;
  logic [WordWidth-1:0]   r_w [16];
  logic [WordWidth-1:0]   r_v [8];
  logic [WordWidth-1:0]   r_h [8];
  logic [6:0]             r_round;
  logic [31:0]            r_block_cnt;
  logic                   r_last;
  logic                   r_first;
  logic [DigestWidth-1:0] r_digest;
  logic                   r_digest_valid;

  logic                   w_block_ready;
  logic                   w_accept;
  logic                   w_digest_take;
  logic [WordWidth-1:0]   w_k;
  logic [WordWidth-1:0]   w_t1;
  logic [WordWidth-1:0]   w_t2;
  logic [WordWidth-1:0]   w_wnew;
  logic [8*WordWidth-1:0] w_hcat;

  assign w_accept      = bus.block_valid_i & w_block_ready;
  assign w_digest_take = r_digest_valid & bus.digest_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.abort_i) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_next_state = ROUND;
        ROUND:   if (r_round == LastRound) w_next_state = UPDATE;
        UPDATE:  w_next_state = r_last ? DONE : IDLE;
        DONE:    if (w_digest_take) w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    w_block_ready = rst_ni & (r_state == IDLE) & ~bus.abort_i;
  end

  // The schedule window shifts every round, so W_t always sits in r_w[0].
  always_comb begin
    w_k    = K[r_round][63 -: WordWidth];
    w_t1   = r_v[7] + big_s1(r_v[4]) + ((r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6])) + w_k + r_w[0];
    w_t2   = big_s0(r_v[0]) + ((r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]));
    w_wnew = small_s1(r_w[14]) + r_w[9] + small_s0(r_w[1]) + r_w[0];
  end

  always_comb begin
    w_hcat = '0;
    for (int i = 0; i < 8; i++) w_hcat[(7-i)*WordWidth +: WordWidth] = r_h[i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        r_v[i] <= '0;
        r_h[i] <= '0;
      end
      r_round        <= '0;
      r_block_cnt    <= '0;
      r_last         <= 1'b0;
      r_first        <= 1'b1;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
    end else if (bus.abort_i) begin
      r_round        <= '0;
      r_block_cnt    <= '0;
      r_first        <= 1'b1;
      r_digest_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            for (int i = 0; i < 16; i++) r_w[i] <= bus.block_i[BlockWidth-1-i*WordWidth -: WordWidth];
            for (int i = 0; i < 8; i++) begin
              if (r_first) begin
                r_h[i] <= iv_word(i);
                r_v[i] <= iv_word(i);
              end else begin
                r_v[i] <= r_h[i];
              end
            end
            r_last  <= bus.block_last_i;
            r_first <= 1'b0;
            r_round <= '0;
          end
        end
        ROUND: begin
          r_v[0] <= w_t1 + w_t2;
          r_v[1] <= r_v[0];
          r_v[2] <= r_v[1];
          r_v[3] <= r_v[2];
          r_v[4] <= r_v[3] + w_t1;
          r_v[5] <= r_v[4];
          r_v[6] <= r_v[5];
          r_v[7] <= r_v[6];
          for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
          r_w[15] <= w_wnew;
          r_round <= (r_round == LastRound) ? 7'd0 : r_round + 7'd1;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_v[i];
          r_block_cnt <= r_block_cnt + 32'd1;
        end
        DONE: begin
          // Digest is registered from H one cycle after the update, then held.
          if (!r_digest_valid) begin
            r_digest       <= w_hcat[8*WordWidth-1 -: DigestWidth];
            r_digest_valid <= 1'b1;
          end else if (bus.digest_ready_i) begin
            r_digest_valid <= 1'b0;
            r_first        <= 1'b1;
            r_block_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.block_ready_o  = w_block_ready;
  assign bus.digest_o       = r_digest;
  assign bus.digest_valid_o = r_digest_valid;
  assign bus.round_o        = r_round;
  assign bus.block_cnt_o    = r_block_cnt;

endmodule

// File: tb/tb_sha2_core.sv
// tb/tb_sha2_core.sv - directed vector bench for sha2_core across all four variants
module tb_sha2_core;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  sha2_core_if #(.WordWidth(32), .DigestWidth(256)) if256 ();
  sha2_core_if #(.WordWidth(32), .DigestWidth(224)) if224 ();
  sha2_core_if #(.WordWidth(64), .DigestWidth(512)) if512 ();
  sha2_core_if #(.WordWidth(64), .DigestWidth(384)) if384 ();

  sha2_core #(.WordWidth(32), .DigestWidth(256)) u_dut256 (.clk_i(clk), .rst_ni(rst_ni), .bus(if256));
  sha2_core #(.WordWidth(32), .DigestWidth(224)) u_dut224 (.clk_i(clk), .rst_ni(rst_ni), .bus(if224));
  sha2_core #(.WordWidth(64), .DigestWidth(512)) u_dut512 (.clk_i(clk), .rst_ni(rst_ni), .bus(if512));
  sha2_core #(.WordWidth(64), .DigestWidth(384)) u_dut384 (.clk_i(clk), .rst_ni(rst_ni), .bus(if384));

  localparam logic [511:0]  ABC256 = {32'h61626380, 448'h0, 32'h18};
  localparam logic [1023:0] ABC512 = {64'h6162638000000000, 896'h0, 64'h18};
  localparam logic [511:0]  TB1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0]  TB2 = {480'h0, 32'h1c0};
  localparam logic [255:0]  D256_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0]  D256_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [223:0]  D224_ABC = 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;
  localparam logic [511:0]  D512_ABC = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
  localparam logic [383:0]  D384_ABC = 384'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7;

  typedef struct {
    logic [511:0] blk;
    logic         last;
    logic [255:0] dig;
    int           cnt;
    int           lat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one time unit after the accepting edge; block_i is then scrambled.
  task automatic send256(input logic [511:0] blk, input logic last);
    int n;
    if256.block_i       = blk;
    if256.block_last_i  = last;
    if256.block_valid_i = 1'b1;
    #1;
    n = 0;
    while (!if256.block_ready_o && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("send_ready", if256.block_ready_o, 1);
    @(posedge clk);
    #1;
    if256.block_valid_i = 1'b0;
    if256.block_i       = '1;
    if256.block_last_i  = ~last;
  endtask

  task automatic wait_valid256(output int n);
    n = 0;
    while (!if256.digest_valid_o && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic take_digest256();
    if256.digest_ready_i = 1'b1;
    tick();
    if256.digest_ready_i = 1'b0;
  endtask

  initial begin
    int n, l224, l384, l512;
    logic ok;
    logic [255:0] saved;
    vec_t tv [4];

    tv[0] = '{ABC256, 1'b1, D256_ABC, 1, 66};
    tv[1] = '{TB1,    1'b0, 256'h0,   1, 65};
    tv[2] = '{TB2,    1'b1, D256_TWO, 2, 66};
    tv[3] = '{ABC256, 1'b1, D256_ABC, 1, 66};

    if256.block_i = '0; if256.block_last_i = 0; if256.block_valid_i = 0; if256.abort_i = 0; if256.digest_ready_i = 0;
    if224.block_i = '0; if224.block_last_i = 0; if224.block_valid_i = 0; if224.abort_i = 0; if224.digest_ready_i = 0;
    if512.block_i = '0; if512.block_last_i = 0; if512.block_valid_i = 0; if512.abort_i = 0; if512.digest_ready_i = 0;
    if384.block_i = '0; if384.block_last_i = 0; if384.block_valid_i = 0; if384.abort_i = 0; if384.digest_ready_i = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_block_ready", if256.block_ready_o, 0);
    check("rst_digest_valid", if256.digest_valid_o, 0);
    check("rst_digest", if256.digest_o, 0);
    check("rst_round", if256.round_o, 0);
    check("rst_block_cnt", if256.block_cnt_o, 0);
    rst_ni = 1'b1;
    #1;
    check("post_rst_ready", if256.block_ready_o, 1);
    tick();

    // Table: one-block, two-block and repeated one-block messages on SHA-256.
    for (int i = 0; i < 4; i++) begin
      send256(tv[i].blk, tv[i].last);
      if (i == 0) check("round_first", if256.round_o, 0);
      if (tv[i].last) begin
        wait_valid256(n);
        check($sformatf("vec%0d_latency", i), n, tv[i].lat);
        check($sformatf("vec%0d_digest", i), if256.digest_o, tv[i].dig);
        check($sformatf("vec%0d_block_cnt", i), if256.block_cnt_o, tv[i].cnt);
        take_digest256();
        check($sformatf("vec%0d_valid_drop", i), if256.digest_valid_o, 0);
        check($sformatf("vec%0d_ready_back", i), if256.block_ready_o, 1);
        check($sformatf("vec%0d_cnt_clear", i), if256.block_cnt_o, 0);
      end else begin
        n = 0;
        while (!if256.block_ready_o && n < 300) begin
          tick();
          n++;
        end
        check($sformatf("vec%0d_ready_latency", i), n, tv[i].lat);
        check($sformatf("vec%0d_block_cnt", i), if256.block_cnt_o, tv[i].cnt);
      end
    end

    // Variant sweep: 224, 512 and 384 hash "abc" in parallel.
    if224.block_i = ABC256; if224.block_last_i = 1; if224.block_valid_i = 1;
    if512.block_i = ABC512; if512.block_last_i = 1; if512.block_valid_i = 1;
    if384.block_i = ABC512; if384.block_last_i = 1; if384.block_valid_i = 1;
    #1;
    check("var_ready", {if224.block_ready_o, if512.block_ready_o, if384.block_ready_o}, 3'b111);
    tick();
    if224.block_valid_i = 0; if512.block_valid_i = 0; if384.block_valid_i = 0;
    l224 = -1; l384 = -1; l512 = -1;
    for (int c = 0; c < 200; c++) begin
      if (if224.digest_valid_o && l224 < 0) l224 = c;
      if (if512.digest_valid_o && l512 < 0) l512 = c;
      if (if384.digest_valid_o && l384 < 0) l384 = c;
      if (l224 >= 0 && l512 >= 0 && l384 >= 0) break;
      tick();
    end
    check("var224_latency", l224, 66);
    check("var512_latency", l512, 82);
    check("var384_latency", l384, 82);
    check("var224_digest", if224.digest_o, D224_ABC);
    check("var512_digest", if512.digest_o, D512_ABC);
    check("var384_digest", if384.digest_o, D384_ABC);
    if224.digest_ready_i = 1; if512.digest_ready_i = 1; if384.digest_ready_i = 1;
    tick();
    if224.digest_ready_i = 0; if512.digest_ready_i = 0; if384.digest_ready_i = 0;
    check("var512_valid_drop", if512.digest_valid_o, 0);

    // Digest backpressure for 20 cycles.
    send256(ABC256, 1'b1);
    wait_valid256(n);
    saved = if256.digest_o;
    check("bp_digest", saved, D256_ABC);
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!if256.digest_valid_o || if256.digest_o !== saved || if256.block_ready_o) ok = 1'b0;
    end
    check("bp_hold_stable", ok, 1);
    take_digest256();
    check("bp_release_valid", if256.digest_valid_o, 0);
    check("bp_release_ready", if256.block_ready_o, 1);
    send256(ABC256, 1'b1);
    wait_valid256(n);
    check("bp_rehash_digest", if256.digest_o, D256_ABC);
    take_digest256();

    // Abort at round 30 of the first block of a two-block message.
    send256(TB1, 1'b0);
    n = 0;
    while (if256.round_o != 7'd30 && n < 64) begin
      tick();
      n++;
    end
    check("abort_round_reach", n, 30);
    if256.abort_i = 1'b1;
    tick();
    check("abort_round", if256.round_o, 0);
    check("abort_block_cnt", if256.block_cnt_o, 0);
    check("abort_valid", if256.digest_valid_o, 0);
    if256.abort_i = 1'b0;
    #1;
    check("abort_idle_ready", if256.block_ready_o, 1);
    send256(ABC256, 1'b1);
    wait_valid256(n);
    check("abort_rehash_latency", n, 66);
    check("abort_rehash_digest", if256.digest_o, D256_ABC);
    check("abort_rehash_cnt", if256.block_cnt_o, 1);
    take_digest256();

    // Abort together with a block offer in IDLE: nothing is accepted.
    if256.block_i = ABC256; if256.block_last_i = 1; if256.block_valid_i = 1; if256.abort_i = 1;
    #1;
    check("abort_blocks_ready", if256.block_ready_o, 0);
    tick();
    if256.block_valid_i = 0; if256.abort_i = 0;
    #1;
    check("abort_no_accept_ready", if256.block_ready_o, 1);
    check("abort_no_accept_round", if256.round_o, 0);

    // Asynchronous reset while rounds are in flight.
    tick();
    send256(ABC256, 1'b1);
    repeat (10) tick();
    #3;
    rst_ni = 1'b0;
    #1;
    check("arst_ready", if256.block_ready_o, 0);
    check("arst_valid", if256.digest_valid_o, 0);
    check("arst_digest", if256.digest_o, 0);
    check("arst_round", if256.round_o, 0);
    check("arst_cnt", if256.block_cnt_o, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    #1;
    check("arst_release_ready", if256.block_ready_o, 1);
    send256(ABC256, 1'b1);
    wait_valid256(n);
    check("arst_rehash_latency", n, 66);
    check("arst_rehash_digest", if256.digest_o, D256_ABC);
    take_digest256();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
